// File: rtl/sn54ls153_mux_bank.sv
// Registered NCH-channel strobed mux bank with a shared select register.
// Optional auto-scan sequencer is built when MUX_AUTOSCAN_EN is defined.
module sn54ls153_mux_bank #(
   parameter int unsigned NCH   = 2,
   parameter int unsigned SEL_W = 2,
   parameter int unsigned DW    = 1,
   parameter int unsigned DWELL = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic [SEL_W-1:0]              i_sel,
   input  logic                          i_sel_ld,
   input  logic [NCH-1:0]                i_g_n,
   input  logic [NCH*(2**SEL_W)*DW-1:0]  i_data,
   input  logic                          i_mode,
   output logic [NCH*DW-1:0]             o_y,
   output logic [SEL_W-1:0]              o_sel_cur,
   output logic                          o_valid,
   output logic                          o_wrap
);

   localparam int unsigned NIN = 2**SEL_W;

   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [NCH*DW-1:0] y_q, y_d;
   logic              valid_q, valid_d;
   logic              wrap_q, wrap_d;
   logic              sel_upd;

   // Mux uses the select value held before this edge, hence 1-cycle stale window.
   always_comb begin
      y_d = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         if (!i_g_n[c])
            y_d[c*DW +: DW] = i_data[(c*NIN + int'(sel_q))*DW +: DW];
      end
   end

`ifdef MUX_AUTOSCAN_EN
   localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          cnt_last;

   assign cnt_last = (cnt_q == CW'(DWELL - 1));

   always_comb begin
      sel_d   = sel_q;
      cnt_d   = '0;
      sel_upd = 1'b0;
      wrap_d  = 1'b0;
      if (i_mode) begin
         if (cnt_last) begin
            sel_d   = sel_q + 1'b1;
            sel_upd = 1'b1;
            wrap_d  = (sel_q == '1);
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (i_sel_ld) begin
         sel_d   = i_sel;
         sel_upd = 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
`else
   logic [1:0] unused_cfg;

   assign unused_cfg = {i_mode, DWELL[0]};

   always_comb begin
      sel_d   = sel_q;
      sel_upd = 1'b0;
      wrap_d  = 1'b0;
      if (i_sel_ld) begin
         sel_d   = i_sel;
         sel_upd = 1'b1;
      end
   end
`endif

   assign valid_d = ~sel_upd;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sel_q   <= '0;
         y_q     <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         sel_q   <= sel_d;
         y_q     <= y_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   assign o_y       = y_q;
   assign o_sel_cur = sel_q;
   assign o_valid   = valid_q;
   assign o_wrap    = wrap_q;

endmodule

// File: tb/tb_sn54ls153_mux_bank.sv
// Directed-vector bench for sn54ls153_mux_bank (default parameters).
// Auto-scan vectors are used when MUX_AUTOSCAN_EN is defined.
module tb_sn54ls153_mux_bank;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] sel;
   logic       sel_ld;
   logic [1:0] g_n;
   logic [7:0] data;
   logic       mode;
   logic [1:0] y;
   logic [1:0] sel_cur;
   logic       valid;
   logic       wrap;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sn54ls153_mux_bank #(
      .NCH   (2),
      .SEL_W (2),
      .DW    (1),
      .DWELL (4)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_sel     (sel),
      .i_sel_ld  (sel_ld),
      .i_g_n     (g_n),
      .i_data    (data),
      .i_mode    (mode),
      .o_y       (y),
      .o_sel_cur (sel_cur),
      .o_valid   (valid),
      .o_wrap    (wrap)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Load a select value manually, then check the stale cycle and the settled output.
   task automatic load_sel(input logic [1:0] s, input logic [1:0] exp_y);
      sel    = s;
      sel_ld = 1'b1;
      step();
      check_eq("ld_valid_lo", valid, 0);
      check_eq("ld_sel_cur", sel_cur, s);
      sel_ld = 1'b0;
      step();
      check_eq("ld_valid_hi", valid, 1);
      check_eq("ld_y", y, exp_y);
   endtask

   initial begin
      rst_n  = 1'b0;
      sel    = 2'd0;
      sel_ld = 1'b0;
      g_n    = 2'b00;
      data   = 8'b0001_1000;
      mode   = 1'b0;
      #12;
      check_eq("rst_y", y, 0);
      check_eq("rst_valid", valid, 0);
      rst_n = 1'b1;
      step();
      check_eq("rst_rel_valid", valid, 1);

      // Manual sweep: ch0 = 1000, ch1 = 0001
      load_sel(2'd0, 2'b10);
      load_sel(2'd1, 2'b00);
      load_sel(2'd2, 2'b00);
      load_sel(2'd3, 2'b01);

      // Strobes at sel 3 with both channels' input 3 high
      data = 8'b1000_1000;
      step();
      check_eq("stb_none", y, 2'b11);
      g_n = 2'b01;
      step();
      check_eq("stb_ch0", y, 2'b10);
      g_n = 2'b11;
      step();
      check_eq("stb_all", y, 2'b00);
      check_eq("stb_sel", sel_cur, 3);
      check_eq("stb_valid", valid, 1);
      g_n = 2'b00;

`ifdef MUX_AUTOSCAN_EN
      load_sel(2'd0, 2'b00);
      mode = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         sel_ld = (k == 6);
         sel    = 2'd2;
         step();
         check_eq("scan_sel", sel_cur, (k / 4) % 4);
         check_eq("scan_wrap", wrap, (k == 16) ? 1 : 0);
         if (k == 4) check_eq("scan_valid", valid, 0);
         if (k == 5) check_eq("scan_valid_hi", valid, 1);
      end
      sel_ld = 1'b0;
      for (int k = 0; k < 8; k++) step();
      check_eq("sw_at2", sel_cur, 2);
      step();
      mode = 1'b0;
      for (int k = 0; k < 5; k++) step();
      check_eq("sw_hold", sel_cur, 2);
      mode = 1'b1;
      for (int k = 0; k < 3; k++) step();
      check_eq("sw_3edges", sel_cur, 2);
      step();
      check_eq("sw_4edges", sel_cur, 3);
      mode = 1'b0;
`else
      mode = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         check_eq("nomac_sel", sel_cur, 3);
         check_eq("nomac_wrap", wrap, 0);
      end
      sel    = 2'd1;
      sel_ld = 1'b1;
      step();
      sel_ld = 1'b0;
      check_eq("nomac_ld", sel_cur, 1);
      step();
      check_eq("nomac_wrap2", wrap, 0);
      mode = 1'b0;
`endif

      // Asynchronous reset mid-run, sampled between edges
      load_sel(2'd3, 2'b11);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_y", y, 0);
      check_eq("mid_rst_sel", sel_cur, 0);
      check_eq("mid_rst_valid", valid, 0);
      check_eq("mid_rst_wrap", wrap, 0);
      #10;
      rst_n = 1'b1;
      step();
      check_eq("mid_rel_valid", valid, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
